// File: rtl/n_bit_adder.sv
`default_nettype none
// ============================================================================
// Module   : n_bit_adder
// Brief    : N-bit ripple-carry adder with carry-in, carry-out, signed overflow
//            and a single registered output stage with valid flag.
//            Optional clamp-on-overflow enabled by N_BIT_ADDER_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module n_bit_adder #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] num1,
    input  logic [N-1:0] num2,
    input  logic         carry_in,
    output logic [N-1:0] sum,
    output logic         carry_out,
    output logic         overflow,
    output logic         out_valid
);

    logic [N:0]   w_carry;
    logic [N-1:0] w_sum;
    logic [N-1:0] w_sum_sel;
    logic         w_overflow;

    logic [N-1:0] r_sum;
    logic         r_carry_out;
    logic         r_overflow;
    logic         r_out_valid;

    assign w_carry[0] = carry_in;

    genvar i;
    generate
        for (i = 0; i < N; i = i + 1) begin : g_bit
            assign w_sum[i]       = num1[i] ^ num2[i] ^ w_carry[i];
            assign w_carry[i + 1] = (num1[i] & num2[i]) |
                                    (num1[i] & w_carry[i]) |
                                    (num2[i] & w_carry[i]);
        end
    endgenerate

    assign w_overflow = w_carry[N] ^ w_carry[N-1];

`ifdef N_BIT_ADDER_SATURATE_EN
    localparam logic [N-1:0] c_sat_max = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] c_sat_min = {1'b1, {(N-1){1'b0}}};

    // Overflow implies equal operand signs, so num1's sign picks the clamp direction
    always_comb begin
        w_sum_sel = w_sum;
        if (w_overflow) begin
            w_sum_sel = num1[N-1] ? c_sat_min : c_sat_max;
        end
    end
`else
    assign w_sum_sel = w_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum       <= w_sum_sel;
                r_carry_out <= w_carry[N];
                r_overflow  <= w_overflow;
            end
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_n_bit_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_n_bit_adder
// Brief    : Scoreboard bench for n_bit_adder; arithmetic reference model,
//            directed corner vectors, back-to-back, random and reset traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_n_bit_adder;

    localparam int N = 5;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] num1;
    logic [N-1:0] num2;
    logic         carry_in;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         out_valid;

    int   checks;
    int   errors;
    exp_t q_exp[$];
    exp_t r_last;

    n_bit_adder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .num1      (num1),
        .num2      (num2),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned and signed integer addition, then range tests
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic ci);
        exp_t         e;
        longint       ua;
        longint       ub;
        longint       sa;
        longint       sb;
        longint       full;
        longint       ss;
        longint       smax;
        longint       smin;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = a[N-1] ? ua - (longint'(1) <<< N) : ua;
        sb   = b[N-1] ? ub - (longint'(1) <<< N) : ub;
        full = ua + ub + longint'(ci);
        ss   = sa + sb + longint'(ci);
        smax = (longint'(1) <<< (N - 1)) - 1;
        smin = -(longint'(1) <<< (N - 1));
        e.sum  = full[N-1:0];
        e.cout = ((full >>> N) & 1) != 0;
        e.ovf  = (ss > smax) || (ss < smin);
`ifdef N_BIT_ADDER_SATURATE_EN
        if (ss > smax) e.sum = smax[N-1:0];
        if (ss < smin) e.sum = smin[N-1:0];
`endif
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic ci);
        @(negedge clk);
        in_valid = v;
        num1     = a;
        num2     = b;
        carry_in = ci;
        @(posedge clk);
        if (v && rst_n) q_exp.push_back(model(a, b, ci));
    endtask

    // Monitor: pops on every out_valid, otherwise checks the outputs hold
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = q_exp.pop_front();
                chk("sum", longint'(sum), longint'(e.sum));
                chk("carry_out", longint'(carry_out), longint'(e.cout));
                chk("overflow", longint'(overflow), longint'(e.ovf));
                r_last = e;
            end
        end else begin
            chk("hold_sum", longint'(sum), longint'(r_last.sum));
            chk("hold_flags", longint'({carry_out, overflow}),
                longint'({r_last.cout, r_last.ovf}));
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        r_last   = '0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        num1     = '0;
        num2     = '0;
        carry_in = 1'b0;
        #1;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_sum", longint'(sum), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Corner vectors
        drive(1'b1, 5'd9,  5'd7,  1'b0);
        drive(1'b1, 5'b10111, 5'd7, 1'b0);
        drive(1'b1, 5'd3,  5'd12, 1'b0);
        drive(1'b1, 5'd31, 5'd1,  1'b0);
        drive(1'b1, 5'd15, 5'd0,  1'b1);
        drive(1'b1, 5'b10000, 5'b11111, 1'b0);
        drive(1'b0, 5'd1,  5'd2,  1'b0);
        drive(1'b0, 5'd21, 5'd6,  1'b1);

        // Back-to-back burst then idle with changing operands
        drive(1'b1, 5'd4,  5'd5,  1'b0);
        drive(1'b1, 5'd14, 5'd14, 1'b1);
        drive(1'b1, 5'd30, 5'd17, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b0, N'($urandom), N'($urandom), 1'($urandom));

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 3) != 0), N'($urandom), N'($urandom), 1'($urandom));
        end

        // Reset mid-stream with a non-zero result in flight
        drive(1'b1, 5'd11, 5'd6, 1'b0);
        drive(1'b1, 5'd13, 5'd2, 1'b0);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        q_exp.delete();
        r_last   = '0;
        #1;
        chk("async_reset_sum", longint'(sum), 0);
        chk("async_reset_flags", longint'({carry_out, overflow}), 0);
        chk("async_reset_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd7, 5'd7, 1'b0);
        drive(1'b0, 5'd9, 5'd9, 1'b1);
        drive(1'b1, 5'd8, 5'd8, 1'b0);
        for (int k = 0; k < 20; k++) begin
            drive(1'($urandom), N'($urandom), N'($urandom), 1'($urandom));
        end
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        @(posedge clk);
        chk("scoreboard_drained", longint'(q_exp.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
